// File: rtl/spi_slave_burst.sv
// Serial slave bridging a single-lane SPI-style master to a synchronous memory port.
// Frame: CMD, ADDR, LEN (all LSB first), then LEN+1 data words written in or shifted out.
module spi_slave_burst #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int LEN_W   = 4,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs,
  input  logic              sdi,
  output logic              sdo,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              mem_wr,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              busy,
  output logic              done,
  output logic              abort
);

  localparam int MAX_A = (ADDR_W > LEN_W) ? ADDR_W : LEN_W;
  localparam int MAX_B = (MAX_A > DATA_W) ? MAX_A : DATA_W;
  localparam int MAX_C = (MAX_B > MEM_LAT + 1) ? MAX_B : MEM_LAT + 1;
  localparam int CNT_W = $clog2(MAX_C + 1);

  localparam logic [CNT_W-1:0] ADDR_LAST  = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] LEN_LAST   = CNT_W'(LEN_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST  = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] FETCH_LAST = CNT_W'(MEM_LAT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_LEN,
    S_WDATA,
    S_RFETCH,
    S_RDATA,
    S_DONE
  } state_t;

  state_t r_state, w_state_next;

  logic              r_cmd;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_word_cnt;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [DATA_W-1:0] r_wshift;
  logic [DATA_W-1:0] r_rshift;

  logic              r_sdo, w_sdo_next;
  logic              r_mem_wr, w_mem_wr_next;
  logic              r_mem_rd, w_mem_rd_next;
  logic              r_done, w_done_next;
  logic              r_abort, w_abort_next;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_next;
  logic [DATA_W-1:0] r_mem_din, w_mem_din_next;

  logic              w_cs_abort;
  logic              w_addr_last;
  logic              w_len_last;
  logic              w_data_last;
  logic              w_fetch_last;
  logic              w_last_word;
  logic [DATA_W-1:0] w_word_in;
  logic [ADDR_W-1:0] w_cur_addr;
  logic [ADDR_W-1:0] w_nxt_addr;

  // cs rising mid-frame aborts; IDLE and DONE are the only places it is legal
  assign w_cs_abort   = cs && (r_state != S_IDLE) && (r_state != S_DONE);
  assign w_addr_last  = (r_bit_cnt == ADDR_LAST);
  assign w_len_last   = (r_bit_cnt == LEN_LAST);
  assign w_data_last  = (r_bit_cnt == DATA_LAST);
  assign w_fetch_last = (r_bit_cnt == FETCH_LAST);
  assign w_last_word  = (r_word_cnt == r_len);
  assign w_word_in    = (r_wshift >> 1) | (DATA_W'(sdi) << (DATA_W - 1));
  assign w_cur_addr   = r_addr + ADDR_W'(r_word_cnt);
  assign w_nxt_addr   = r_addr + ADDR_W'(r_word_cnt) + ADDR_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (!cs) w_state_next = S_ADDR;
      end
      S_ADDR: begin
        if (cs)               w_state_next = S_IDLE;
        else if (w_addr_last) w_state_next = S_LEN;
      end
      S_LEN: begin
        if (cs)              w_state_next = S_IDLE;
        else if (w_len_last) w_state_next = r_cmd ? S_WDATA : S_RFETCH;
      end
      S_WDATA: begin
        if (cs)                              w_state_next = S_IDLE;
        else if (w_data_last && w_last_word) w_state_next = S_DONE;
      end
      S_RFETCH: begin
        if (cs)                w_state_next = S_IDLE;
        else if (w_fetch_last) w_state_next = S_RDATA;
      end
      S_RDATA: begin
        if (cs)               w_state_next = S_IDLE;
        else if (w_data_last) w_state_next = w_last_word ? S_DONE : S_RFETCH;
      end
      S_DONE: begin
        if (cs) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Next values for the registered outputs; the abort check overrides any strobe.
  always_comb begin
    w_sdo_next      = 1'b0;
    w_mem_wr_next   = 1'b0;
    w_mem_rd_next   = 1'b0;
    w_done_next     = 1'b0;
    w_abort_next    = 1'b0;
    w_mem_addr_next = r_mem_addr;
    w_mem_din_next  = r_mem_din;
    busy            = (r_state != S_IDLE);
    if (w_cs_abort) begin
      w_abort_next = 1'b1;
    end else begin
      case (r_state)
        S_LEN: begin
          if (w_len_last && !r_cmd) begin
            w_mem_rd_next   = 1'b1;
            w_mem_addr_next = r_addr;
          end
        end
        S_WDATA: begin
          if (w_data_last) begin
            w_mem_wr_next   = 1'b1;
            w_mem_addr_next = w_cur_addr;
            w_mem_din_next  = w_word_in;
            w_done_next     = w_last_word;
          end
        end
        S_RFETCH: begin
          if (w_fetch_last) w_sdo_next = mem_dout[0];
        end
        S_RDATA: begin
          if (!w_data_last) begin
            w_sdo_next = r_rshift[0];
          end else if (w_last_word) begin
            w_done_next = 1'b1;
          end else begin
            w_mem_rd_next   = 1'b1;
            w_mem_addr_next = w_nxt_addr;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sdo      <= 1'b0;
      r_mem_wr   <= 1'b0;
      r_mem_rd   <= 1'b0;
      r_done     <= 1'b0;
      r_abort    <= 1'b0;
      r_mem_addr <= '0;
      r_mem_din  <= '0;
    end else begin
      r_sdo      <= w_sdo_next;
      r_mem_wr   <= w_mem_wr_next;
      r_mem_rd   <= w_mem_rd_next;
      r_done     <= w_done_next;
      r_abort    <= w_abort_next;
      r_mem_addr <= w_mem_addr_next;
      r_mem_din  <= w_mem_din_next;
    end
  end

  // Field shifters and counters; IDLE clears the counters so an aborted frame leaves no residue.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cmd      <= 1'b0;
      r_addr     <= '0;
      r_len      <= '0;
      r_word_cnt <= '0;
      r_bit_cnt  <= '0;
      r_wshift   <= '0;
      r_rshift   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_bit_cnt  <= '0;
          r_word_cnt <= '0;
          if (!cs) r_cmd <= sdi;
        end
        S_ADDR: begin
          r_addr    <= (r_addr >> 1) | (ADDR_W'(sdi) << (ADDR_W - 1));
          r_bit_cnt <= w_addr_last ? '0 : r_bit_cnt + 1'b1;
        end
        S_LEN: begin
          r_len     <= (r_len >> 1) | (LEN_W'(sdi) << (LEN_W - 1));
          r_bit_cnt <= w_len_last ? '0 : r_bit_cnt + 1'b1;
        end
        S_WDATA: begin
          r_wshift <= w_word_in;
          if (w_data_last) begin
            r_bit_cnt  <= '0;
            r_word_cnt <= r_word_cnt + 1'b1;
          end else begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end
        S_RFETCH: begin
          if (w_fetch_last) begin
            r_bit_cnt <= '0;
            r_rshift  <= mem_dout >> 1;
          end else begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end
        S_RDATA: begin
          r_rshift <= r_rshift >> 1;
          if (w_data_last) begin
            r_bit_cnt  <= '0;
            r_word_cnt <= r_word_cnt + 1'b1;
          end else begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign sdo      = r_sdo;
  assign mem_wr   = r_mem_wr;
  assign mem_rd   = r_mem_rd;
  assign done     = r_done;
  assign abort    = r_abort;
  assign mem_addr = r_mem_addr;
  assign mem_din  = r_mem_din;

endmodule

// File: tb/tb_spi_slave_burst.sv
// Bench for spi_slave_burst: per-cycle expectations derived from frame timing arithmetic,
// a memory model on the DUT port, and literal checks of the words moved.
`timescale 1ns/1ps
module tb_spi_slave_burst;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int LW = 4;
  localparam int ML = 1;
  localparam int NC = 1024;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cs  = 1'b1;
  logic       sdi = 1'b0;
  logic       sdo, mem_wr, mem_rd, busy, done, abort;
  logic [7:0] mem_dout, mem_addr, mem_din;

  always #5 clk = ~clk;

  spi_slave_burst #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .MEM_LAT(ML)) dut (
    .clk(clk), .rst(rst), .cs(cs), .sdi(sdi), .sdo(sdo), .mem_dout(mem_dout),
    .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_din(mem_din),
    .busy(busy), .done(done), .abort(abort)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory on the DUT port; returns junk on cycles without a read so a mistimed capture shows.
  logic [7:0] dmem [256];
  always @(posedge clk) begin
    if (mem_wr) dmem[mem_addr] <= mem_din;
    if (mem_rd) mem_dout <= dmem[mem_addr];
    else        mem_dout <= 8'($urandom);
  end

  logic       e_wr [NC], e_rd [NC], e_done [NC], e_abort [NC], e_busy [NC], e_sdo [NC], e_sv [NC];
  logic [7:0] e_addr [NC], e_din [NC];
  logic [7:0] mmem [256];
  logic [7:0] wbuf [16];

  int n_tests = 0;
  int n_fail  = 0;
  int chk_en  = 0;
  logic [15:0] wr_log [$];
  logic        sdo_log [$];
  int n_rd_seen    = 0;
  int n_abort_seen = 0;

  always @(negedge clk) begin
    if (chk_en != 0 && cyc < NC) begin
      n_tests++;
      if (sdo !== e_sdo[cyc] || busy !== e_busy[cyc] || mem_wr !== e_wr[cyc] ||
          mem_rd !== e_rd[cyc] || done !== e_done[cyc] || abort !== e_abort[cyc] ||
          ((e_wr[cyc] || e_rd[cyc]) && mem_addr !== e_addr[cyc]) ||
          (e_wr[cyc] && mem_din !== e_din[cyc])) begin
        n_fail++;
        $display("FAIL cycle%0d outputs: got sdo=%b busy=%b wr=%b rd=%b done=%b abort=%b addr=%02h din=%02h; expected sdo=%b busy=%b wr=%b rd=%b done=%b abort=%b addr=%02h din=%02h",
                 cyc, sdo, busy, mem_wr, mem_rd, done, abort, mem_addr, mem_din,
                 e_sdo[cyc], e_busy[cyc], e_wr[cyc], e_rd[cyc], e_done[cyc], e_abort[cyc],
                 e_addr[cyc], e_din[cyc]);
      end
      if (e_sv[cyc]) sdo_log.push_back(sdo);
    end
    if (mem_wr) wr_log.push_back({mem_addr, mem_din});
    if (mem_rd) n_rd_seen++;
    if (abort)  n_abort_seen++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      cs  = 1'b1;
      sdi = 1'b0;
    end
  endtask

  task automatic check(input string nm, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic int wr_at(input int idx);
    if (idx < wr_log.size()) return int'(wr_log[idx]);
    return -1;
  endfunction

  function automatic int rd_byte(input int start, input int j);
    int v;
    v = 0;
    if (start + (j + 1) * DW > sdo_log.size()) return -1;
    for (int i = 0; i < DW; i++)
      if (sdo_log[start + j * DW + i]) v = v | (1 << i);
    return v;
  endfunction

  // Write frame of len+1 words from wbuf; abort_bits >= 0 raises cs after that many data bits.
  task automatic wr_frame(input logic [7:0] a, input int len, input int abort_bits);
    int t0, d0, nb, tend, c;
    logic [7:0] ad;
    tick();
    t0  = cyc;
    cs  = 1'b0;
    sdi = 1'b1;
    d0   = t0 + 1 + AW + LW;
    nb   = (abort_bits >= 0) ? abort_bits : (len + 1) * DW;
    tend = d0 + nb;
    for (int k = t0 + 1; k <= tend; k++) e_busy[k] = 1'b1;
    for (int k = 0; (k + 1) * DW <= nb; k++) begin
      c = d0 + (k + 1) * DW;
      ad = a + 8'(k);
      e_wr[c]   = 1'b1;
      e_addr[c] = ad;
      e_din[c]  = wbuf[k];
      mmem[ad]  = wbuf[k];
    end
    if (abort_bits >= 0) e_abort[tend + 1] = 1'b1;
    else                 e_done[tend] = 1'b1;
    for (int i = 0; i < AW; i++) begin tick(); sdi = a[i]; end
    for (int i = 0; i < LW; i++) begin tick(); sdi = len[i]; end
    for (int b = 0; b < nb; b++) begin tick(); sdi = wbuf[b / DW][b % DW]; end
    tick();
    cs  = 1'b1;
    sdi = 1'b0;
  endtask

  // Read frame of len+1 words; rst_off >= 0 pulses rst that many cycles after the header.
  task automatic rd_frame(input logic [7:0] a, input int len, input int rst_off);
    int t0, d0, per, e, stop, f, c;
    logic [7:0] ad;
    tick();
    t0  = cyc;
    cs  = 1'b0;
    sdi = 1'b0;
    d0   = t0 + 1 + AW + LW;
    per  = 1 + ML + DW;
    e    = d0 + (len + 1) * per;
    stop = (rst_off >= 0) ? d0 + rst_off : e;
    for (int k = t0 + 1; k <= stop; k++) e_busy[k] = 1'b1;
    for (int k = 0; k <= len; k++) begin
      f  = d0 + k * per;
      ad = a + 8'(k);
      if (f <= stop) begin
        e_rd[f]   = 1'b1;
        e_addr[f] = ad;
      end
      for (int i = 0; i < DW; i++) begin
        c = f + 1 + ML + i;
        if (c <= stop) begin
          e_sdo[c] = mmem[ad][i];
          e_sv[c]  = 1'b1;
        end
      end
    end
    if (rst_off < 0) e_done[e] = 1'b1;
    for (int i = 0; i < AW; i++) begin tick(); sdi = a[i]; end
    for (int i = 0; i < LW; i++) begin tick(); sdi = len[i]; end
    while (1) begin
      tick();
      if (cyc >= stop) break;
      sdi = 1'($urandom);
    end
    cs  = 1'b1;
    sdi = 1'b0;
    if (rst_off >= 0) begin
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst_mid_mem_addr", int'(mem_addr), 0);
      check("rst_mid_busy", int'(busy), 0);
    end
  endtask

  int w0, s0, r0, a0;

  initial begin
    for (int i = 0; i < NC; i++) begin
      e_wr[i] = 0; e_rd[i] = 0; e_done[i] = 0; e_abort[i] = 0;
      e_busy[i] = 0; e_sdo[i] = 0; e_sv[i] = 0; e_addr[i] = 0; e_din[i] = 0;
    end
    for (int i = 0; i < 256; i++) mmem[i] = 8'h00;
    for (int i = 0; i < 16; i++) wbuf[i] = 8'h00;

    tick();
    chk_en = 1;
    tick();
    tick();
    check("reset_busy", int'(busy), 0);
    check("reset_mem_addr", int'(mem_addr), 0);
    check("reset_mem_din", int'(mem_din), 0);
    rst = 1'b0;
    idle(2);

    // single-word write
    w0 = wr_log.size();
    wbuf[0] = 8'hA5;
    wr_frame(8'h3C, 0, -1);
    idle(2);
    check("t1_nwr", wr_log.size() - w0, 1);
    check("t1_wr", wr_at(w0), 16'h3CA5);

    // burst write wrapping past 0xFF
    w0 = wr_log.size();
    wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33;
    wr_frame(8'hFE, 2, -1);
    idle(2);
    check("t2_nwr", wr_log.size() - w0, 3);
    check("t2_wr0", wr_at(w0), 16'hFE11);
    check("t2_wr1", wr_at(w0 + 1), 16'hFF22);
    check("t2_wr2", wr_at(w0 + 2), 16'h0033);

    // preload then burst read
    wbuf[0] = 8'h5A; wbuf[1] = 8'hC3;
    wr_frame(8'h10, 1, -1);
    idle(2);
    s0 = sdo_log.size();
    r0 = n_rd_seen;
    rd_frame(8'h10, 1, -1);
    idle(2);
    check("t3_nrd", n_rd_seen - r0, 2);
    check("t3_byte0", rd_byte(s0, 0), 8'h5A);
    check("t3_byte1", rd_byte(s0, 1), 8'hC3);

    // abort after 12 data bits: first word lands, second discarded
    w0 = wr_log.size();
    a0 = n_abort_seen;
    wbuf[0] = 8'h96; wbuf[1] = 8'h3F;
    wr_frame(8'h40, 1, 12);
    idle(2);
    check("t4_nwr", wr_log.size() - w0, 1);
    check("t4_wr", wr_at(w0), 16'h4096);
    check("t4_nabort", n_abort_seen - a0, 1);

    // abort on the last bit of a word: write suppressed
    w0 = wr_log.size();
    a0 = n_abort_seen;
    wbuf[0] = 8'hE7;
    wr_frame(8'h50, 0, 7);
    idle(2);
    check("t4b_nwr", wr_log.size() - w0, 0);
    check("t4b_nabort", n_abort_seen - a0, 1);

    // reset during RDATA, then a clean read
    wbuf[0] = 8'hDE; wbuf[1] = 8'hAD; wbuf[2] = 8'hBE; wbuf[3] = 8'hEF;
    wr_frame(8'h20, 3, -1);
    idle(2);
    rd_frame(8'h20, 1, 1 + ML + 3);
    idle(2);
    s0 = sdo_log.size();
    rd_frame(8'h21, 2, -1);
    idle(2);
    check("t5_byte0", rd_byte(s0, 0), 8'hAD);
    check("t5_byte1", rd_byte(s0, 1), 8'hBE);
    check("t5_byte2", rd_byte(s0, 2), 8'hEF);

    // back-to-back write then read of the same word
    wbuf[0] = 8'h77;
    wr_frame(8'h05, 0, -1);
    idle(1);
    s0 = sdo_log.size();
    rd_frame(8'h05, 0, -1);
    idle(2);
    check("t6_byte", rd_byte(s0, 0), 8'h77);

    // read burst wrapping past 0xFF
    s0 = sdo_log.size();
    rd_frame(8'hFE, 2, -1);
    idle(3);
    check("t7_byte0", rd_byte(s0, 0), 8'h11);
    check("t7_byte1", rd_byte(s0, 1), 8'h22);
    check("t7_byte2", rd_byte(s0, 2), 8'h33);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
